// File: rtl/multi_cycle_ctrl_if.sv
// Bundle of signals between the multi-cycle control FSM and the datapath.
// The master side is the controller. The slave side is the datapath and memory.
interface multi_cycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             IRWr;
  logic             PCWr;
  logic             PCWrCond;
  logic [1:0]       PCSrc;
  logic             MemRd;
  logic             MemWr;
  logic             IorD;
  logic             RegWr;
  logic             RegDst;
  logic             MemtoReg;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] ill_cnt;

  modport master (
    input  op, zero, mem_ready,
    output IRWr, PCWr, PCWrCond, PCSrc, MemRd, MemWr, IorD, RegWr, RegDst,
           MemtoReg, ALUSrcB, ALUOp, illegal, state, retired, ill_cnt
  );

  modport slave (
    output op, zero, mem_ready,
    input  IRWr, PCWr, PCWrCond, PCSrc, MemRd, MemWr, IorD, RegWr, RegDst,
           MemtoReg, ALUSrcB, ALUOp, illegal, state, retired, ill_cnt
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the instruction-register / field-decoder datapath.
// It steps each instruction through IF, ID, EX, MEM and WB according to its opcode class.
// The IF and MEM states stall on mem_ready.
// The module counts retired instructions and illegal opcodes.
module multi_cycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  multi_cycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_LW, C_SW, C_ADDI, C_BEQ, C_J, C_ILL
  } cls_e;

  state_e           state_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] ill_q;
  cls_e             cls;
  logic             retire;
  logic             ill_hit;

  // The datapath consumes the zero flag directly through PCWrCond.
  // The controller itself never needs it.
  logic unused_zero;
  assign unused_zero = bus.zero;

  // Sort the opcode into its instruction class.
  function automatic cls_e decode(input logic [5:0] op);
    cls_e c;
    case (op[5:4])
      2'b00: c = C_R;
      2'b01: begin
        case (op[3:0])
          4'h0:    c = C_LW;
          4'h1:    c = C_SW;
          4'h2:    c = C_ADDI;
          4'h3:    c = C_BEQ;
          default: c = C_ILL;
        endcase
      end
      2'b10:   c = C_J;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  assign cls = decode(bus.op);

  // Control outputs decoded from state, class and mem_ready. All outputs are held at 0 while in reset.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bus.IRWr     = 1'b0;
    bus.PCWr     = 1'b0;
    bus.PCWrCond = 1'b0;
    bus.PCSrc    = 2'b00;
    bus.MemRd    = 1'b0;
    bus.MemWr    = 1'b0;
    bus.IorD     = 1'b0;
    bus.RegWr    = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.ALUOp    = 2'b00;
    bus.illegal  = 1'b0;
    retire       = 1'b0;
    ill_hit      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IF: begin
          bus.MemRd = 1'b1;
          if (bus.mem_ready) begin
            bus.IRWr    = 1'b1;
            bus.PCWr    = 1'b1;
            bus.ALUSrcB = 2'b01;
          end
        end
        S_ID: begin
          bus.ALUSrcB = 2'b11;
          if (cls == C_ILL) begin
            bus.illegal = 1'b1;
            ill_hit     = 1'b1;
          end
        end
        S_EX: begin
          case (cls)
            C_R: bus.ALUOp = 2'b10;
            C_LW, C_SW, C_ADDI: bus.ALUSrcB = 2'b10;
            C_BEQ: begin
              bus.ALUOp    = 2'b01;
              bus.PCWrCond = 1'b1;
              bus.PCSrc    = 2'b01;
              retire       = 1'b1;
            end
            C_J: begin
              bus.PCWr  = 1'b1;
              bus.PCSrc = 2'b10;
              retire    = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.IorD  = 1'b1;
          bus.MemRd = (cls == C_LW);
          bus.MemWr = (cls == C_SW);
          retire    = (cls == C_SW) && bus.mem_ready;
        end
        S_WB: begin
          bus.RegWr    = 1'b1;
          bus.RegDst   = (cls == C_R);
          bus.MemtoReg = (cls == C_LW);
          retire       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state   = rst ? 3'd0 : state_q;
  assign bus.retired = retired_q;
  assign bus.ill_cnt = ill_q;

  // State sequencing and the wrapping retired / illegal counters.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q   <= S_IF;
      retired_q <= '0;
      ill_q     <= '0;
    end else begin
      if (retire)  retired_q <= retired_q + CNT_W'(1);
      if (ill_hit) ill_q     <= ill_q + CNT_W'(1);
      case (state_q)
        S_IF:  if (bus.mem_ready) state_q <= S_ID;
        S_ID:  state_q <= (cls == C_ILL) ? S_IF : S_EX;
        S_EX: begin
          case (cls)
            C_R, C_ADDI: state_q <= S_WB;
            C_LW, C_SW:  state_q <= S_MEM;
            default:     state_q <= S_IF;
          endcase
        end
        S_MEM: if (bus.mem_ready) state_q <= (cls == C_LW) ? S_WB : S_IF;
        S_WB:  state_q <= S_IF;
        default: state_q <= S_IF;
      endcase
    end
  end

endmodule
